neo_pattern_sequencer: RTL and testbench
========================================

// Module: neo_pattern_sequencer
// PURPOSE
//  Parametrised successor to the static NeoPixel pattern tables. It generates LED load
//  commands (pixel index plus colour) from counters at run time instead of fixed arrays.
//  Sits between the switch-synchronised mode inputs and the NeoPixel driver.
//  Issues loads_per_frame loads, then requests a display, then waits for the driver to finish.
// PARAMETERS
//  NUM_PIXELS  5  LEDs on the strip (>=1); pixel index width PW = max(1,$clog2(NUM_PIXELS))
//  COLOR_W     8  intensity width of one palette entry
//  LOAD_W      7  width of loads_per_frame
// PORTS
//  clock            in   1          system clock; single clock domain
//  reset            in   1          synchronous, active-high
//  enable           in   1          allows a new frame to start
//  mode             in   2          0 CHASE, 1 ALT, 2 BOUNCE, 3 TWINKLE
//  freeze           in   1          1 = repeat current frame (hold colour)
//  loads_per_frame  in   LOAD_W     loads per frame; 0 treated as 1
//  palette          in   4*COLOR_W  hue entries; entry i = palette[i*COLOR_W +: COLOR_W]
//  cmd_valid        out  1          load command valid
//  cmd_ready        in   1          driver accepts command
//  cmd_pixel        out  PW         pixel to load
//  cmd_color        out  COLOR_W    palette[hue_idx]
//  send_req         out  1          one-cycle pulse: display loaded pixels
//  send_done        in   1          driver finished display
//  busy             out  1          state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; cmd_valid=0, send_req=0, busy=0, cmd_pixel=0, cmd_color=0.
//   Counters cleared: pix=0, dir=up, lap=0, cnt=0, act_mode=0, snapshot=0.
//  FSM IDLE->LOAD->SEND->WAIT->IDLE:
//   IDLE: when enable=1, go to LOAD next cycle.
//    If mode!=act_mode: set act_mode=mode; clear pix, dir, lap.
//    Snapshot {pix,dir,lap}; clear cnt; capture lim=max(loads_per_frame,1).
//   LOAD: cmd_valid=1. cmd_pixel/cmd_color are registered.
//    They hold stable while cmd_valid && !cmd_ready.
//    On accept (valid&&ready): cnt++, advance counters.
//    If cnt+1==lim, drop valid next cycle and go to SEND.
//    Otherwise present the next command next cycle; no bubble allowed.
//   SEND: send_req=1 for exactly one cycle, then go to WAIT.
//   WAIT: on send_done, go to IDLE. If freeze=1 in that cycle, restore {pix,dir,lap}
//    from snapshot so the next frame repeats.
//    send_done outside WAIT is ignored.
//  Advance rules (applied on each accepted load):
//   CHASE/ALT/TWINKLE: pix = pix==N-1 ? 0 : pix+1; lap++ (2-bit, wraps) when pix wraps.
//   BOUNCE: ping-pong. If dir=up && pix==N-1: dir=down, lap++.
//    If dir=down && pix==0: dir=up, lap++.
//    pix then steps one in the new dir; N=1 keeps pix=0 and increments lap on every load.
//  hue_idx (from pix/lap of the command being issued):
//   CHASE: lap.  ALT: (pix+lap) mod 4.  BOUNCE: lap.  TWINKLE: {lap[0],pix[0]}.
//  mode, loads_per_frame and palette are sampled only in IDLE (frame boundary).
//   Mid-frame changes have no effect until the next frame.
//  cmd_valid never asserts in SEND, WAIT or IDLE. send_req and cmd_valid are mutually exclusive.
//  Reset asserted mid-frame: next cycle is IDLE with all outputs at their reset values.
//   No send_req is issued for the partial frame.
//  Arithmetic: cnt is LOAD_W wide. The pix and lap wrap rules above are explicit, not modular.
// TESTING  (N=5, palette = {8'h20,8'h10,8'h05,8'h00}; entry 0 = 8'h00)
//  T1 CHASE, lpf=3, ready=1, send_done 2 cycles after send_req.
//   Frame 1 = (0,00)(1,00)(2,00), send_req.
//   Frame 2 = (3,00)(4,00)(0,05).
//  T2 BOUNCE, lpf=10: pixels 0,1,2,3,4,3,2,1,0,1.
//   Colours 00 x5, then 05 x4, then 10 x1.
//  T3 ALT, lpf=7: colours 00,05,10,20,00,05,10 (pixels 0-4,0,1).
//   Then TWINKLE fresh: 00,05,00,05,00 for pixels 0-4.
//  T4 freeze=1 at send_done, CHASE lpf=3: frame 2 repeats (0,00)(1,00)(2,00).
//   Release freeze: frame continues at pixel 3.
//  T5 Backpressure: ready=0 for 4 cycles mid-frame. cmd_pixel/cmd_color stable.
//   No count advance. Change mode mid-frame: ignored until IDLE, then counters clear.
//  T6 lpf=0 -> 1 load per frame. Reset mid-LOAD -> cmd_valid=0 next cycle.
//   Then a fresh frame starts at (0,00).

Source files
------------

// File: rtl/neo_pattern_sequencer.sv
// neo_pattern_sequencer
//   Generates NeoPixel load commands (pixel index + palette colour) from run-time
//   counters. Each frame issues max(loads_per_frame,1) loads, pulses send_req,
//   then waits for the driver's send_done before the next frame may start.
// Ports
//   clock_i, reset_i          single clock, synchronous active-high reset
//   enable_i                  allows a new frame to start from IDLE
//   mode_i                    0 CHASE, 1 ALT, 2 BOUNCE, 3 TWINKLE (sampled in IDLE)
//   freeze_i                  at send_done: rewind counters so the frame repeats
//   loads_per_frame_i         loads per frame, 0 treated as 1 (sampled in IDLE)
//   palette_i                 four hue entries, entry i at [i*COLOR_W +: COLOR_W]
//   cmd_valid_o/cmd_ready_i   load command handshake
//   cmd_pixel_o, cmd_color_o  registered command payload
//   send_req_o                one-cycle display request
//   send_done_i               driver finished display (honoured only in WAIT)
//   busy_o                    FSM not in IDLE
module neo_pattern_sequencer #(
  parameter int NUM_PIXELS = 5,
  parameter int COLOR_W    = 8,
  parameter int LOAD_W     = 7,
  localparam int PW        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [1:0]           mode_i,
  input  logic                 freeze_i,
  input  logic [LOAD_W-1:0]    loads_per_frame_i,
  input  logic [4*COLOR_W-1:0] palette_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [PW-1:0]        cmd_pixel_o,
  output logic [COLOR_W-1:0]   cmd_color_o,
  output logic                 send_req_o,
  input  logic                 send_done_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

  localparam logic [1:0]    M_BOUNCE = 2'd2;
  localparam logic [PW-1:0] LAST     = PW'(NUM_PIXELS - 1);

  state_t               state_q, state_d;
  logic [PW-1:0]        pix_q, snap_pix_q, cmd_pixel_q;
  logic                 dir_q, snap_dir_q;          // 0 = up, 1 = down
  logic [1:0]           lap_q, snap_lap_q, act_mode_q;
  logic [LOAD_W-1:0]    cnt_q, lim_q;
  logic [4*COLOR_W-1:0] pal_q;
  logic [COLOR_W-1:0]   cmd_color_q;

  logic                 accept, last_load, mode_chg;
  logic [PW-1:0]        adv_pix, st_pix;
  logic                 adv_dir, st_dir;
  logic [1:0]           adv_lap, st_lap;

  function automatic logic [1:0] hue(input logic [1:0] m, input logic [PW-1:0] p,
                                     input logic [1:0] l);
    case (m)
      2'd1:    hue = 2'(p) + l;
      2'd3:    hue = {l[0], p[0]};
      default: hue = l;
    endcase
  endfunction

  function automatic logic [COLOR_W-1:0] pal_sel(input logic [4*COLOR_W-1:0] pal,
                                                 input logic [1:0] idx);
    pal_sel = pal[idx*COLOR_W +: COLOR_W];
  endfunction

  assign accept    = (state_q == S_LOAD) && cmd_ready_i;
  assign last_load = (cnt_q + LOAD_W'(1)) == lim_q;

  // A mode change at a frame boundary restarts the pattern from pixel 0.
  assign mode_chg = mode_i != act_mode_q;
  assign st_pix   = mode_chg ? '0   : pix_q;
  assign st_dir   = mode_chg ? 1'b0 : dir_q;
  assign st_lap   = mode_chg ? 2'd0 : lap_q;

  // Counter advance for one accepted load.
  always_comb begin
    adv_pix = pix_q;
    adv_dir = dir_q;
    adv_lap = lap_q;
    if (act_mode_q == M_BOUNCE) begin
      if (NUM_PIXELS == 1) begin
        // Single LED: every load hits an end, so only the lap moves.
        adv_dir = ~dir_q;
        adv_lap = lap_q + 2'd1;
      end else if (!dir_q && pix_q == LAST) begin
        adv_dir = 1'b1;
        adv_lap = lap_q + 2'd1;
        adv_pix = pix_q - PW'(1);
      end else if (dir_q && pix_q == '0) begin
        adv_dir = 1'b0;
        adv_lap = lap_q + 2'd1;
        adv_pix = pix_q + PW'(1);
      end else begin
        adv_pix = dir_q ? pix_q - PW'(1) : pix_q + PW'(1);
      end
    end else if (pix_q == LAST) begin
      adv_pix = '0;
      adv_lap = lap_q + 2'd1;
    end else begin
      adv_pix = pix_q + PW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable_i)              state_d = S_LOAD;
      S_LOAD:  if (accept && last_load)   state_d = S_SEND;
      S_SEND:                             state_d = S_WAIT;
      S_WAIT:  if (send_done_i)           state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_valid_o = (state_q == S_LOAD);
    send_req_o  = (state_q == S_SEND);
    busy_o      = (state_q != S_IDLE);
  end

  assign cmd_pixel_o = cmd_pixel_q;
  assign cmd_color_o = cmd_color_q;

  // Datapath: counters, frame snapshot and registered command payload.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pix_q       <= '0;
      dir_q       <= 1'b0;
      lap_q       <= '0;
      snap_pix_q  <= '0;
      snap_dir_q  <= 1'b0;
      snap_lap_q  <= '0;
      act_mode_q  <= '0;
      cnt_q       <= '0;
      lim_q       <= '0;
      pal_q       <= '0;
      cmd_pixel_q <= '0;
      cmd_color_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (enable_i) begin
          act_mode_q  <= mode_i;
          pix_q       <= st_pix;
          dir_q       <= st_dir;
          lap_q       <= st_lap;
          snap_pix_q  <= st_pix;
          snap_dir_q  <= st_dir;
          snap_lap_q  <= st_lap;
          cnt_q       <= '0;
          lim_q       <= (loads_per_frame_i == '0) ? LOAD_W'(1) : loads_per_frame_i;
          pal_q       <= palette_i;
          cmd_pixel_q <= st_pix;
          cmd_color_q <= pal_sel(palette_i, hue(mode_i, st_pix, st_lap));
        end
        // The next command is precomputed on accept so valid never bubbles.
        S_LOAD: if (accept) begin
          cnt_q       <= cnt_q + LOAD_W'(1);
          pix_q       <= adv_pix;
          dir_q       <= adv_dir;
          lap_q       <= adv_lap;
          cmd_pixel_q <= adv_pix;
          cmd_color_q <= pal_sel(pal_q, hue(act_mode_q, adv_pix, adv_lap));
        end
        S_WAIT: if (send_done_i && freeze_i) begin
          pix_q <= snap_pix_q;
          dir_q <= snap_dir_q;
          lap_q <= snap_lap_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_pattern_sequencer.sv
// Scoreboard bench: each frame's expected commands (taken from the pattern
// definitions) are queued before the frame is launched and popped on every
// accepted load.
module tb_neo_pattern_sequencer;
  localparam int N  = 5;
  localparam int CW = 8;
  localparam int LW = 7;
  localparam int PW = 3;
  localparam logic [4*CW-1:0] PAL = {8'h20, 8'h10, 8'h05, 8'h00};

  logic          clock = 1'b0;
  logic          reset, enable, freeze, cmd_ready, send_done;
  logic [1:0]    mode;
  logic [LW-1:0] lpf;
  logic [4*CW-1:0] palette;
  logic          cmd_valid, send_req, busy;
  logic [PW-1:0] cmd_pixel;
  logic [CW-1:0] cmd_color;

  always #5 clock = ~clock;

  neo_pattern_sequencer #(.NUM_PIXELS(N), .COLOR_W(CW), .LOAD_W(LW)) dut (
    .clock_i(clock), .reset_i(reset), .enable_i(enable), .mode_i(mode),
    .freeze_i(freeze), .loads_per_frame_i(lpf), .palette_i(palette),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_pixel_o(cmd_pixel),
    .cmd_color_o(cmd_color), .send_req_o(send_req), .send_done_i(send_done),
    .busy_o(busy)
  );

  typedef struct { int pix; int col; } cmd_t;
  cmd_t expq[$];
  cmd_t e;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input int c);
    expq.push_back('{pix: p, col: c});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: compare every accepted load against the queue head.
  always @(negedge clock) begin
    if (!reset && cmd_valid && cmd_ready) begin
      check("excl_valid_send", {31'd0, send_req}, 0);
      if (expq.size() == 0) begin
        check("unexpected_cmd", 1, 0);
      end else begin
        e = expq.pop_front();
        check("cmd_pixel", 32'(cmd_pixel), e.pix);
        check("cmd_color", 32'(cmd_color), e.col);
      end
    end
  end

  // Launch one frame and drive the driver side (send_done 2 cycles after send_req).
  // With stall set, ready drops for 4 cycles after the second accept while mode
  // and palette are changed underneath the running frame.
  task automatic run_frame(input logic [1:0] m, input int n, input logic frz, input bit stall);
    int acc;
    bit seen;
    logic [PW-1:0] hp;
    logic [CW-1:0] hc;
    acc     = 0;
    seen    = 0;
    mode    = m;
    lpf     = LW'(n);
    palette = PAL;
    enable  = 1'b1;
    step();
    enable  = 1'b0;
    check("valid_at_start", {31'd0, cmd_valid}, 1);
    for (int i = 0; i < 300; i++) begin
      if (send_req) begin
        seen = 1;
        break;
      end
      if (stall && acc == 2) begin
        hp = cmd_pixel;
        hc = cmd_color;
        cmd_ready = 1'b0;
        mode      = 2'd1;
        palette   = 32'hFFFF_FFFF;
        repeat (4) begin
          step();
          check("stall_pixel", 32'(cmd_pixel), 32'(hp));
          check("stall_color", 32'(cmd_color), 32'(hc));
          check("stall_valid", {31'd0, cmd_valid}, 1);
        end
        cmd_ready = 1'b1;
        stall = 0;
      end
      if (cmd_valid && cmd_ready) acc++;
      step();
    end
    check("send_seen", {31'd0, seen}, 1);
    check("send_no_valid", {31'd0, cmd_valid}, 0);
    step();
    check("send_one_cycle", {31'd0, send_req}, 0);
    check("busy_in_wait", {31'd0, busy}, 1);
    step();
    send_done = 1'b1;
    freeze    = frz;
    step();
    send_done = 1'b0;
    freeze    = 1'b0;
    check("idle_after_done", {31'd0, busy}, 0);
    check("frame_drained", expq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; freeze = 1'b0; cmd_ready = 1'b1; send_done = 1'b0;
    mode = 2'd0; lpf = '0; palette = PAL;
    step();
    step();
    check("rst_valid", {31'd0, cmd_valid}, 0);
    check("rst_send",  {31'd0, send_req}, 0);
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_pixel", 32'(cmd_pixel), 0);
    check("rst_color", 32'(cmd_color), 0);
    reset = 1'b0;
    step();

    // T1 CHASE, 3 loads, two frames
    push(0, 8'h00); push(1, 8'h00); push(2, 8'h00);
    run_frame(2'd0, 3, 1'b0, 0);
    push(3, 8'h00); push(4, 8'h00); push(0, 8'h05);
    run_frame(2'd0, 3, 1'b0, 0);

    // T2 BOUNCE, 10 loads
    for (int p = 0; p < 5; p++) push(p, 8'h00);
    for (int p = 3; p >= 0; p--) push(p, 8'h05);
    push(1, 8'h10);
    run_frame(2'd2, 10, 1'b0, 0);

    // T3 ALT 7 loads, then TWINKLE from fresh counters
    push(0, 8'h00); push(1, 8'h05); push(2, 8'h10); push(3, 8'h20);
    push(4, 8'h00); push(0, 8'h05); push(1, 8'h10);
    run_frame(2'd1, 7, 1'b0, 0);
    push(0, 8'h00); push(1, 8'h05); push(2, 8'h00); push(3, 8'h05); push(4, 8'h00);
    run_frame(2'd3, 5, 1'b0, 0);

    // T4 freeze at send_done repeats the frame; released freeze continues
    for (int r = 0; r < 2; r++) begin
      push(0, 8'h00); push(1, 8'h00); push(2, 8'h00);
      run_frame(2'd0, 3, (r == 0), 0);
    end
    push(3, 8'h00); push(4, 8'h00); push(0, 8'h05);
    run_frame(2'd0, 3, 1'b0, 0);

    // T5 backpressure with mid-frame mode/palette change, then ALT clears counters
    push(1, 8'h05); push(2, 8'h05); push(3, 8'h05); push(4, 8'h05);
    run_frame(2'd0, 4, 1'b0, 1);
    push(0, 8'h00); push(1, 8'h05);
    run_frame(2'd1, 2, 1'b0, 0);

    // T6 lpf=0 gives one load; reset mid-LOAD; fresh frame afterwards
    push(0, 8'h00);
    run_frame(2'd0, 0, 1'b0, 0);
    mode = 2'd0; lpf = LW'(5); cmd_ready = 1'b0; enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    check("pre_rst_valid", {31'd0, cmd_valid}, 1);
    check("pre_rst_pixel", 32'(cmd_pixel), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", {31'd0, cmd_valid}, 0);
    check("midrst_busy",  {31'd0, busy}, 0);
    check("midrst_pixel", 32'(cmd_pixel), 0);
    check("midrst_color", 32'(cmd_color), 0);
    cmd_ready = 1'b1;
    repeat (3) begin
      step();
      check("midrst_no_send", {31'd0, send_req}, 0);
    end
    push(0, 8'h00); push(1, 8'h00);
    run_frame(2'd0, 2, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
